// File: rtl/qosc_pkg.sv
// Shared definitions for the quadrature oscillator and its configuration loader.
// The config struct is packed MSB-first, in the same order the words arrive on the wire.
package qosc_pkg;

   localparam logic [7:0] QOSC_HDR    = 8'hA5;
   localparam int         QOSC_NWORDS = 5;
   localparam int         QOSC_NBYTES = 10;

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      CSUM
   } qosc_state_e;

   typedef struct packed {
      logic signed [15:0] re_coeff;
      logic signed [15:0] im_coeff;
      logic signed [15:0] power;
      logic signed [15:0] accu_re_init;
      logic signed [15:0] accu_im_init;
   } qosc_cfg_t;

endpackage

// File: rtl/qosc_gap_timer.sv
// Counts idle cycles between bytes inside a frame.
// expire_o fires on the cycle the count would reach TIMEOUT; a clear in that cycle wins.
module qosc_gap_timer #(
   parameter int TIMEOUT = 1023
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);

   localparam int W = $clog2(TIMEOUT + 1);

   logic [W-1:0] cnt_q, cnt_d;

   assign expire_o = en_i && !clr_i && (cnt_q == W'(TIMEOUT - 1));

   // NOTE: cnt_d is defaulted first so every path assigns it and no latch is inferred.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i || expire_o) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/qosc_cfg_loader.sv
// Assembles a byte-serial config frame (header, 10 data bytes, XOR checksum) into the
// five oscillator words and publishes them with a one-cycle load pulse on a good checksum.
module qosc_cfg_loader
   import qosc_pkg::*;
#(
   parameter logic [7:0] HEADER  = QOSC_HDR,
   parameter int         TIMEOUT = 1023
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               byte_valid,
   input  logic [7:0]         byte_data,
   input  logic               err_clr,
   output logic signed [15:0] re_coeff,
   output logic signed [15:0] im_coeff,
   output logic signed [15:0] power,
   output logic signed [15:0] accu_re_init,
   output logic signed [15:0] accu_im_init,
   output logic               load,
   output logic               busy,
   output logic               crc_err,
   output logic               timeout_err
);

   localparam int IDX_W = $clog2(QOSC_NBYTES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(QOSC_NBYTES - 1);

   qosc_state_e                  state_q;
   logic [IDX_W-1:0]             idx_q;
   logic [7:0]                   csum_q;
   logic [QOSC_NBYTES*8-1:0]     stage_q;
   qosc_cfg_t                    cfg_q;
   logic                         load_q;
   logic                         crc_err_q;
   logic                         timeout_err_q;
   logic                         gap_expire;

   qosc_gap_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_gap_timer (
      .clk      (clk),
      .rst      (rst),
      .clr_i    (byte_valid || (state_q == IDLE)),
      .en_i     (state_q != IDLE),
      .expire_o (gap_expire)
   );

   // NOTE: all state here uses <= so every register samples pre-edge values; the later
   // error assignments override the err_clr clear in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         idx_q         <= '0;
         csum_q        <= '0;
         stage_q       <= '0;
         cfg_q         <= '0;
         load_q        <= 1'b0;
         crc_err_q     <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         load_q <= 1'b0;
         if (err_clr) begin
            crc_err_q     <= 1'b0;
            timeout_err_q <= 1'b0;
         end
         case (state_q)
            IDLE: begin
               if (byte_valid && (byte_data == HEADER)) begin
                  state_q <= DATA;
                  idx_q   <= '0;
                  csum_q  <= '0;
               end
            end
            DATA: begin
               if (byte_valid) begin
                  stage_q <= {stage_q[QOSC_NBYTES*8-9:0], byte_data};
                  csum_q  <= csum_q ^ byte_data;
                  idx_q   <= idx_q + 1'b1;
                  if (idx_q == LAST_IDX) begin
                     state_q <= CSUM;
                  end
               end else if (gap_expire) begin
                  state_q       <= IDLE;
                  stage_q       <= '0;
                  timeout_err_q <= 1'b1;
               end
            end
            CSUM: begin
               if (byte_valid) begin
                  state_q <= IDLE;
                  if (byte_data == csum_q) begin
                     cfg_q  <= qosc_cfg_t'(stage_q);
                     load_q <= 1'b1;
                  end else begin
                     crc_err_q <= 1'b1;
                  end
               end else if (gap_expire) begin
                  state_q       <= IDLE;
                  stage_q       <= '0;
                  timeout_err_q <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign re_coeff     = cfg_q.re_coeff;
   assign im_coeff     = cfg_q.im_coeff;
   assign power        = cfg_q.power;
   assign accu_re_init = cfg_q.accu_re_init;
   assign accu_im_init = cfg_q.accu_im_init;
   assign load         = load_q;
   assign busy         = (state_q != IDLE);
   assign crc_err      = crc_err_q;
   assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_qosc_cfg_loader.sv
// Directed bench for qosc_cfg_loader with TIMEOUT=8; inputs change and outputs are
// sampled on the falling edge, expected values are hand-computed frame contents.
module tb_qosc_cfg_loader;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               byte_valid = 1'b0;
   logic [7:0]         byte_data = 8'h00;
   logic               err_clr = 1'b0;
   logic signed [15:0] re_coeff, im_coeff, power, accu_re_init, accu_im_init;
   logic               load, busy, crc_err, timeout_err;

   int n_vec = 0;
   int n_err = 0;
   int load_cnt = 0;

   always #5 clk = ~clk;

   qosc_cfg_loader #(
      .HEADER  (8'hA5),
      .TIMEOUT (8)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .byte_valid   (byte_valid),
      .byte_data    (byte_data),
      .err_clr      (err_clr),
      .re_coeff     (re_coeff),
      .im_coeff     (im_coeff),
      .power        (power),
      .accu_re_init (accu_re_init),
      .accu_im_init (accu_im_init),
      .load         (load),
      .busy         (busy),
      .crc_err      (crc_err),
      .timeout_err  (timeout_err)
   );

   always @(negedge clk) if (load) load_cnt++;

   // re=7D34 im=1A9D power=0400 accre=0020 accim=0000, csum EA
   logic [7:0] f1 [12] = '{8'hA5, 8'h7D, 8'h34, 8'h1A, 8'h9D, 8'h04, 8'h00,
                           8'h00, 8'h20, 8'h00, 8'h00, 8'hEA};
   logic [7:0] f1_bad [12] = '{8'hA5, 8'h7D, 8'h34, 8'h1A, 8'h9D, 8'h04, 8'h00,
                               8'h00, 8'h20, 8'h00, 8'h00, 8'hEB};
   // re=1234 im=5678 power=9ABC accre=DEF0 accim=0FF0, csum FF
   logic [7:0] f3 [12] = '{8'hA5, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC,
                           8'hDE, 8'hF0, 8'h0F, 8'hF0, 8'hFF};
   // header value inside data; re=A5A5 im=0001 power=8000 accre=FFFF accim=0002, csum 83
   logic [7:0] f4 [12] = '{8'hA5, 8'hA5, 8'hA5, 8'h00, 8'h01, 8'h80, 8'h00,
                           8'hFF, 8'hFF, 8'h00, 8'h02, 8'h83};

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic put(input logic [7:0] b);
      @(negedge clk);
      byte_valid = 1'b1;
      byte_data  = b;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         byte_valid = 1'b0;
      end
   endtask

   task automatic put_range(input logic [7:0] f [12], input int lo, input int hi);
      for (int i = lo; i <= hi; i++) put(f[i]);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      byte_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic pulse_clr();
      @(negedge clk);
      byte_valid = 1'b0;
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
   endtask

   task automatic check_words(input string tag, input logic [15:0] re, input logic [15:0] im,
                              input logic [15:0] pw, input logic [15:0] ar, input logic [15:0] ai);
      check({tag, ".re"}, re_coeff, re);
      check({tag, ".im"}, im_coeff, im);
      check({tag, ".pw"}, power, pw);
      check({tag, ".ar"}, accu_re_init, ar);
      check({tag, ".ai"}, accu_im_init, ai);
   endtask

   initial begin
      int base;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check_words("rst", 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
      check("rst.load", load, 1'b0);
      check("rst.busy", busy, 1'b0);
      check("rst.crc", crc_err, 1'b0);
      check("rst.to", timeout_err, 1'b0);

      // good frame, checking load latency and one-cycle width
      put_range(f1, 0, 11);
      check("good.busy_csum", busy, 1'b1);
      idle(1);
      check("good.load", load, 1'b1);
      check("good.re_lat", re_coeff, 16'h7D34);
      check("good.busy", busy, 1'b0);
      idle(1);
      check("good.load_drop", load, 1'b0);
      check("good.cnt", load_cnt, 1);
      check_words("good", 16'h7D34, 16'h1A9D, 16'h0400, 16'h0020, 16'h0000);
      check("good.crc", crc_err, 1'b0);
      check("good.to", timeout_err, 1'b0);

      // bad checksum after reset
      do_reset();
      base = load_cnt;
      put_range(f1_bad, 0, 11);
      idle(2);
      check("bad.cnt", load_cnt, base);
      check("bad.crc", crc_err, 1'b1);
      check_words("bad", 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
      pulse_clr();
      check("bad.clr", crc_err, 1'b0);

      // timeout: 8 empty cycles in DATA abort the frame
      put(8'hA5);
      put(8'h7D);
      idle(8);
      check("to.busy_pre", busy, 1'b1);
      check("to.flag_pre", timeout_err, 1'b0);
      idle(1);
      check("to.flag", timeout_err, 1'b1);
      check("to.busy", busy, 1'b0);
      check("to.cnt", load_cnt, base);
      put_range(f1, 0, 11);
      idle(2);
      check("to.reload_cnt", load_cnt, base + 1);
      check_words("to.reload", 16'h7D34, 16'h1A9D, 16'h0400, 16'h0020, 16'h0000);
      pulse_clr();
      check("to.clr", timeout_err, 1'b0);

      // boundary: byte lands exactly when the gap would expire
      base = load_cnt;
      put(8'hA5);
      put(8'h12);
      idle(7);
      put_range(f3, 2, 11);
      idle(2);
      check("edge.to", timeout_err, 1'b0);
      check("edge.cnt", load_cnt, base + 1);
      check_words("edge", 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 16'h0FF0);

      // junk bytes while idle
      put(8'h00);
      put(8'hFF);
      idle(3);
      check("junk.busy", busy, 1'b0);
      check("junk.crc", crc_err, 1'b0);
      check("junk.to", timeout_err, 1'b0);
      check("junk.cnt", load_cnt, base + 1);

      // back-to-back, second header in the first frame's load cycle
      base = load_cnt;
      put_range(f1, 0, 11);
      @(negedge clk);
      check("b2b.load1", load, 1'b1);
      check("b2b.re1", re_coeff, 16'h7D34);
      byte_valid = 1'b1;
      byte_data  = f4[0];
      put_range(f4, 1, 11);
      idle(2);
      check("b2b.cnt", load_cnt, base + 2);
      check("b2b.crc", crc_err, 1'b0);
      check_words("b2b", 16'hA5A5, 16'h0001, 16'h8000, 16'hFFFF, 16'h0002);

      // reset mid-frame, then a normal frame
      base = load_cnt;
      put_range(f3, 0, 5);
      do_reset();
      check("mid.busy", busy, 1'b0);
      check("mid.cnt", load_cnt, base);
      check_words("mid", 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
      put_range(f1, 0, 11);
      idle(2);
      check("mid.reload_cnt", load_cnt, base + 1);
      check_words("mid.reload", 16'h7D34, 16'h1A9D, 16'h0400, 16'h0020, 16'h0000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/qosc_cfg_loader.md
Name: qosc_cfg_loader

Overview:
Upstream configuration stage for the quadrature oscillator. Receives a byte-serial frame from the 8-bit user input pins, assembles the five signed 16-bit oscillator words (re_coeff, im_coeff, power, accu_re_init, accu_im_init), and validates them with an XOR checksum. On a good frame it updates its output registers and issues a one-cycle load pulse that preloads the oscillator. Bad or stalled frames are discarded, and sticky error flags are raised.

Parameters:
HEADER, 8'hA5, start-of-frame byte value
TIMEOUT, 1023, maximum idle cycles allowed between bytes inside a frame before the frame is aborted (must be >= 1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
byte_valid  input  1  single-cycle strobe: byte_data is valid this cycle; no back-pressure, every strobe is consumed
byte_data  input  8  frame byte
err_clr  input  1  clears crc_err and timeout_err
re_coeff  output  16  signed rotation coefficient, real part
im_coeff  output  16  signed rotation coefficient, imaginary part
power  output  16  signed target power level
accu_re_init  output  16  signed initial accumulator, real part
accu_im_init  output  16  signed initial accumulator, imaginary part
load  output  1  one-cycle pulse: outputs hold a freshly validated frame
busy  output  1  high while in DATA or CSUM
crc_err  output  1  sticky: a checksum mismatch occurred
timeout_err  output  1  sticky: a frame was aborted by timeout

Behaviour:
- Reset (rst=1 at a clock edge): all five word outputs=0, load=0, busy=0, crc_err=0, timeout_err=0, state=IDLE, byte index=0, checksum accumulator=0, gap counter=0. Reset mid-frame discards the partial frame and leaves the outputs at 0.
- Frame format: HEADER, then 10 data bytes, then 1 checksum byte.
  - Data bytes carry the words in order re_coeff, im_coeff, power, accu_re_init, accu_im_init, each MSB first.
  - The checksum is the XOR of the 10 data bytes, seeded with 0x00. The header is not included.
- FSM:
  - IDLE: byte_valid with byte_data==HEADER -> DATA, with index=0 and checksum=0. Any other byte is ignored silently.
  - DATA: each byte_valid writes a staging register (not the outputs), XORs the byte into the checksum, and increments index. After the 10th byte -> CSUM. A HEADER value received in DATA is ordinary data.
  - CSUM: byte_valid -> IDLE.
    - Match: copy the staging registers to the outputs and pulse load on the next cycle.
    - Mismatch: set crc_err and leave the outputs unchanged.
- Latency: the outputs change and load=1 in the cycle after the clock edge that samples the checksum byte. load lasts exactly 1 cycle, and the outputs are stable from that cycle until the next good frame.
- Back-to-back frames: the FSM is already in IDLE during the load cycle, so a HEADER strobed in that cycle starts a new frame.
- Timeout:
  - The gap counter resets to 0 on every byte_valid, and increments each cycle in DATA or CSUM without byte_valid.
  - When it reaches TIMEOUT: -> IDLE, set timeout_err, drop the staging data, no load.
  - If byte_valid arrives in the same cycle the counter would reach TIMEOUT, the byte wins and no timeout occurs.
  - The counter is held at 0 in IDLE. Its width is clog2(TIMEOUT+1).
- busy=1 exactly while in DATA or CSUM.
- Sticky flags: an err_clr pulse clears both flags. If err_clr coincides with a new error event, the error wins and the flag stays set.
- No arithmetic is performed on the words; they are stored bit-exact and interpreted as two's complement downstream.

Decomposition:
- Shared package qosc_pkg:
  - constant QOSC_HDR=8'hA5
  - constant QOSC_NWORDS=5
  - constant QOSC_NBYTES=10
  - state typedef {IDLE, DATA, CSUM}
  - typedef for the 5-word config struct, so the oscillator and this loader share one definition
- One natural sub-module: qosc_gap_timer (gap counter with clear/enable/expire).

Test Plan:
- Good frame: A5 7D 34 1A 9D 04 00 00 20 00 00 EA, bytes on consecutive cycles -> single load pulse. The outputs then read re_coeff=7D34, im_coeff=1A9D, power=0400, accu_re_init=0020, accu_im_init=0000. No error flags.
- Bad checksum: the same frame with checksum EB -> no load, crc_err=1, outputs still 0 (post-reset). err_clr then clears crc_err.
- Timeout with TIMEOUT=8: A5 7D then a 9-cycle gap -> timeout_err=1, busy=0, no load. A full good frame sent afterwards loads correctly.
- Boundary: the next byte arrives exactly at gap cycle TIMEOUT -> the frame continues. Junk bytes 00 FF in IDLE -> ignored, no flags.
- Back-to-back: two good frames, the second header strobed in the load cycle of the first -> two load pulses, with outputs showing the second frame's values.
- Reset mid-frame: rst asserted after 5 data bytes -> outputs 0, busy 0, no load. A subsequent good frame loads normally.
